// File: rtl/pix_pkg.sv
// Shared defaults, FSM state type and tap indexing for the 3x3 window generator.
package pix_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned IMG_W_DEF = 256;
  localparam int unsigned IMG_H_DEF = 256;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FLUSH
  } state_e;

  // Row-major tap order: TL is packed into the top DW bits of the window.
  localparam int unsigned TAP_TL = 0;
  localparam int unsigned TAP_TC = 1;
  localparam int unsigned TAP_TR = 2;
  localparam int unsigned TAP_ML = 3;
  localparam int unsigned TAP_MC = 4;
  localparam int unsigned TAP_MR = 5;
  localparam int unsigned TAP_BL = 6;
  localparam int unsigned TAP_BC = 7;
  localparam int unsigned TAP_BR = 8;
  localparam int unsigned NTAPS  = 9;

  function automatic logic [NTAPS-1:0] border_keep(input logic top, input logic bot,
                                                   input logic left, input logic right);
    logic [NTAPS-1:0] keep;
    keep = '1;
    if (top) begin
      keep[TAP_TL] = 1'b0;
      keep[TAP_TC] = 1'b0;
      keep[TAP_TR] = 1'b0;
    end
    if (bot) begin
      keep[TAP_BL] = 1'b0;
      keep[TAP_BC] = 1'b0;
      keep[TAP_BR] = 1'b0;
    end
    if (left) begin
      keep[TAP_TL] = 1'b0;
      keep[TAP_ML] = 1'b0;
      keep[TAP_BL] = 1'b0;
    end
    if (right) begin
      keep[TAP_TR] = 1'b0;
      keep[TAP_MR] = 1'b0;
      keep[TAP_BR] = 1'b0;
    end
    return keep;
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Fixed-delay line buffer: dout_o is the sample written DEPTH enabled shifts ago.
module line_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;

  // Read-before-write at the same slot gives exactly DEPTH shifts of delay.
  assign dout_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to one zero-padded 3x3 neighbourhood per pixel, centred in raster order.
module window_gen_3x3
  import pix_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [9*DW-1:0]            win,
  output logic                       win_valid,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       frame_end
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   in_col_q, in_col_d, oc_q, oc_d;
  logic [RW-1:0]   in_row_q, in_row_d, or_q, or_d;
  logic            rdy_q;
  logic [DW-1:0]   c1_q [3];
  logic [DW-1:0]   c2_q [3];
  logic [DW-1:0]   taps [NTAPS];
  logic [NTAPS-1:0] keep;
  logic [9*DW-1:0] win_q, win_d;
  logic            win_valid_q, frame_end_q;
  logic [RW-1:0]   out_row_q;
  logic [CW-1:0]   out_col_q;

  logic          xfer, flushing, shift_en, emit, in_last, out_last;
  logic [DW-1:0] pix_eff, mid_new, top_new;

  assign pix_ready = rdy_q;
  assign xfer      = pix_valid & rdy_q;
  assign flushing  = (state_q == FLUSH);
  assign shift_en  = xfer | flushing;
  assign emit      = flushing | (xfer & (state_q == RUN));
  assign pix_eff   = flushing ? '0 : pix_in;
  assign in_last   = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
  assign out_last  = (or_q == ROW_LAST) && (oc_q == COL_LAST);

  line_fifo #(.DW(DW), .DEPTH(IMG_W)) u_lb_mid (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (shift_en),
    .din_i (pix_eff),
    .dout_o(mid_new)
  );

  line_fifo #(.DW(DW), .DEPTH(IMG_W)) u_lb_top (
    .clk_i (clk),
    .rst_ni(rst),
    .en_i  (shift_en),
    .din_i (mid_new),
    .dout_o(top_new)
  );

  // Window is built from the post-shift view so it can be registered in the transfer cycle.
  always_comb begin
    taps[TAP_TL] = c1_q[0];
    taps[TAP_TC] = c2_q[0];
    taps[TAP_TR] = top_new;
    taps[TAP_ML] = c1_q[1];
    taps[TAP_MC] = c2_q[1];
    taps[TAP_MR] = mid_new;
    taps[TAP_BL] = c1_q[2];
    taps[TAP_BC] = c2_q[2];
    taps[TAP_BR] = pix_eff;
    keep  = border_keep(or_q == '0, or_q == ROW_LAST, oc_q == '0, oc_q == COL_LAST);
    win_d = '0;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      win_d[(NTAPS-i)*DW-1 -: DW] = keep[i] ? taps[i] : '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    oc_d     = oc_q;
    or_d     = or_q;
    if (xfer) begin
      in_col_d = (in_col_q == COL_LAST) ? '0 : in_col_q + 1'b1;
      if (in_col_q == COL_LAST) begin
        in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
      end
    end
    if (emit) begin
      oc_d = (oc_q == COL_LAST) ? '0 : oc_q + 1'b1;
      if (oc_q == COL_LAST) begin
        or_d = (or_q == ROW_LAST) ? '0 : or_q + 1'b1;
      end
    end
    case (state_q)
      FILL:  if (xfer && in_row_q == RW'(1) && in_col_q == '0) state_d = RUN;
      RUN:   if (xfer && in_last) state_d = FLUSH;
      FLUSH: begin
        if (out_last) begin
          state_d  = FILL;
          in_col_d = '0;
          in_row_d = '0;
          oc_d     = '0;
          or_d     = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      in_col_q    <= '0;
      in_row_q    <= '0;
      oc_q        <= '0;
      or_q        <= '0;
      rdy_q       <= 1'b0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      frame_end_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        c1_q[i] <= '0;
        c2_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      oc_q        <= oc_d;
      or_q        <= or_d;
      rdy_q       <= (state_d != FLUSH);
      win_valid_q <= emit;
      frame_end_q <= flushing & out_last;
      if (emit) begin
        win_q     <= win_d;
        out_row_q <= or_q;
        out_col_q <= oc_q;
      end
      if (shift_en) begin
        c1_q[0] <= c2_q[0];
        c2_q[0] <= top_new;
        c1_q[1] <= c2_q[1];
        c2_q[1] <= mid_new;
        c1_q[2] <= c2_q[2];
        c2_q[2] <= pix_eff;
      end
    end
  end

  assign win       = win_q;
  assign win_valid = win_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench: 4x4 directed frames on one instance, 256x256 ramp on a default-sized instance.
module tb_window_gen_3x3;

  localparam int unsigned DW = 8;
  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [DW-1:0]  pix_in;
  logic           pix_valid, pix_ready;
  logic [71:0]    win;
  logic           win_valid;
  logic [1:0]     out_row, out_col;
  logic           frame_end;

  logic [7:0]     b_pix;
  logic           b_valid, b_ready;
  logic [71:0]    b_win;
  logic           b_wv;
  logic [7:0]     b_row, b_col;
  logic           b_fe;

  window_gen_3x3 #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win(win), .win_valid(win_valid), .out_row(out_row), .out_col(out_col), .frame_end(frame_end)
  );

  window_gen_3x3 dut_big (
    .clk(clk), .rst(rst), .pix_in(b_pix), .pix_valid(b_valid), .pix_ready(b_ready),
    .win(b_win), .win_valid(b_wv), .out_row(b_row), .out_col(b_col), .frame_end(b_fe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [71:0] win;
    int          row;
    int          col;
    logic        fe;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [71:0] model_win(input int base, input int r, input int c);
    logic [71:0] w;
    int px;
    w = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (r + dr < 0 || r + dr >= H || c + dc < 0 || c + dc >= W) px = 0;
        else px = base + (r + dr) * W + (c + dc);
        w = {w[63:0], px[7:0]};
      end
    end
    return w;
  endfunction

  function automatic bit hand_win(input int base, input int r, input int c, output logic [71:0] w);
    w = '0;
    if (base == 1 && r == 1 && c == 1) w = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    else if (base == 1 && r == 0 && c == 0) w = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6};
    else if (base == 1 && r == 3 && c == 3) w = {8'd11, 8'd12, 8'd0, 8'd15, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0};
    else if (base == 1 && r == 0 && c == 3) w = {8'd0, 8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd7, 8'd8, 8'd0};
    else if (base == 1 && r == 2 && c == 0) w = {8'd0, 8'd5, 8'd6, 8'd0, 8'd9, 8'd10, 8'd0, 8'd13, 8'd14};
    else if (base == 17 && r == 0 && c == 0) w = {8'd0, 8'd0, 8'd0, 8'd0, 8'd17, 8'd18, 8'd0, 8'd21, 8'd22};
    else return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_win(input int base, input int r, input int c);
    exp_t e;
    logic [71:0] hw;
    if (hand_win(base, r, c, hw)) e.win = hw;
    else e.win = model_win(base, r, c);
    e.row = r;
    e.col = c;
    e.fe  = (r == H - 1 && c == W - 1);
    sb.push_back(e);
  endtask

  task automatic push_frame(input int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) push_win(base, r, c);
  endtask

  // Entered and left on a falling edge; the transfer happens on the rising edge between.
  task automatic send_pix(input logic [7:0] v);
    int t;
    t = 0;
    pix_in    = v;
    pix_valid = 1'b1;
    while (pix_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout at %0t: pix_ready=%b, required 1", $time, pix_ready);
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input int npix, input bit gaps, input bit lat_check);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        pix_valid = 1'b0;
        pix_in    = 8'($urandom);
        @(negedge clk);
      end
      send_pix(8'(base + i));
      if (lat_check) chk("win_valid_latency", 72'(win_valid), 72'(i >= W + 1));
    end
  endtask

  task automatic check_flush();
    chk("flush_ready", 72'(pix_ready), 72'(0));
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("flush_ready", 72'(pix_ready), 72'(0));
    end
    @(negedge clk);
    chk("ready_after_frame_end", 72'(pix_ready), 72'(1));
    chk("frame_end_after_flush", 72'(frame_end), 72'(1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 72'(sb.size()), 72'(0));
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && win_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_window at %0t: got win=%h row=%0d col=%0d, required none",
                 $time, win, out_row, out_col);
      end else begin
        mon_e = sb.pop_front();
        chk("win", win, mon_e.win);
        chk("out_row", 72'(out_row), 72'(mon_e.row));
        chk("out_col", 72'(out_col), 72'(mon_e.col));
        chk("frame_end", 72'(frame_end), 72'(mon_e.fe));
      end
    end
  end

  int b_er = 0, b_ec = 0, b_cnt = 0, b_fe_cnt = 0;
  always @(negedge clk) begin
    if (rst === 1'b1 && b_wv === 1'b1) begin
      chk("big_centre", 72'(b_win[39:32]), 72'((b_er + b_ec) & 255));
      chk("big_pos", 72'({b_row, b_col}), 72'(b_er * 256 + b_ec));
      chk("big_frame_end", 72'(b_fe), 72'(b_er == 255 && b_ec == 255));
      b_cnt++;
      if (b_fe) b_fe_cnt++;
      if (b_ec == 255) begin
        b_ec = 0;
        b_er = (b_er == 255) ? 0 : b_er + 1;
      end else begin
        b_ec++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst       = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    b_valid   = 1'b0;
    b_pix     = '0;

    @(negedge clk);
    chk("reset_win", win, 72'(0));
    chk("reset_win_valid", 72'(win_valid), 72'(0));
    chk("reset_frame_end", 72'(frame_end), 72'(0));
    chk("reset_out_row", 72'(out_row), 72'(0));
    chk("reset_out_col", 72'(out_col), 72'(0));
    chk("reset_pix_ready", 72'(pix_ready), 72'(0));
    @(negedge clk);
    rst = 1'b1;

    // Continuous frame with latency and flush checks
    push_frame(1);
    send_frame(1, W * H, 1'b0, 1'b1);
    check_flush();
    drain();

    // Random valid gaps
    push_frame(1);
    send_frame(1, W * H, 1'b1, 1'b0);
    check_flush();
    drain();

    // Back-to-back frames
    push_frame(1);
    push_frame(17);
    send_frame(1, W * H, 1'b0, 1'b0);
    send_frame(17, W * H, 1'b0, 1'b0);
    drain();

    // Reset after pixel 9
    for (int c = 0; c < W; c++) push_win(1, 0, c);
    send_frame(1, 9, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_win_valid", 72'(win_valid), 72'(0));
    chk("midreset_pix_ready", 72'(pix_ready), 72'(0));
    chk("midreset_win", win, 72'(0));
    chk("midreset_pending", 72'(sb.size()), 72'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    push_frame(1);
    send_frame(1, W * H, 1'b0, 1'b1);
    drain();

    // Default 256x256 ramp
    for (int r = 0; r < 256; r++) begin
      for (int c = 0; c < 256; c++) begin
        b_pix   = 8'(r + c);
        b_valid = 1'b1;
        t = 0;
        while (b_ready !== 1'b1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        if (t >= 100) begin
          n_checks++;
          n_fail++;
          $display("FAIL big_ready_timeout at %0t: b_ready=%b, required 1", $time, b_ready);
        end
        @(negedge clk);
        b_valid = 1'b0;
      end
    end
    t = 0;
    while (b_fe_cnt == 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("big_window_count", 72'(b_cnt), 72'(65536));
    chk("big_frame_end_count", 72'(b_fe_cnt), 72'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
